store_buffer: RTL and testbench

Posted-write buffer between the multicycle CPU's data port (`memwrite`, `dataaddr`, `writedata`) and the data memory. Stores are captured into a small FIFO so the CPU does not wait on memory, then drained in order over a valid/ready memory port. Loads are serialised behind outstanding stores, with optional youngest-match forwarding. Instantiated beside `cpu` at the top level.

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/store_buffer_fifo.sv | 65 ++++++
 rtl/store_buffer.sv | 155 +++++++++++++++
 tb/tb_store_buffer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the CPU-side store buffer: scalar aliases, controller
// state encoding and the FIFO entry layout {word address, data}.
package common;

   typedef logic        u1;
   typedef logic [31:0] u32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_REQ  = 2'd1,
      RD_WAIT = 2'd2
   } sb_state_t;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
   } sb_entry_t;

   localparam int SB_ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/store_buffer_fifo.sv
// sb_fifo: circular store storage with head/tail pointers and an occupancy count.
// The caller never pushes when full nor pops when empty.
module sb_fifo #(
   parameter int  DEPTH = 4,
   parameter int  EW    = 62,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [EW-1:0]             push_data,
   input  logic                      pop,
   output logic [EW-1:0]             head_data,
   output logic                      full,
   output logic                      empty,
   output logic [CW-1:0]             count,
   output logic [PW-1:0]             head_ptr,
   output logic [DEPTH-1:0][EW-1:0]  entries
);

   logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
   logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]            count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         mem_d[tail_q] = push_data;
         tail_d        = tail_q + 1'b1;
      end
      if (pop)
         head_d = head_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_data = mem_q[head_q];
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_ptr  = head_q;
   assign entries   = mem_q;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU data port and data memory; loads wait for
// the buffer to drain. Define STORE_BUF_FWD_EN for youngest-match load forwarding.
module store_buffer
   import common::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic        memread,
   input  logic [31:0] dataaddr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        stall,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   sb_state_t   state_q, state_d;
   logic [29:0] rd_addr_q, rd_addr_d;

   logic                             push, pop, full, empty;
   logic [SB_ENTRY_W-1:0]            push_data, head_data;
   logic [CW-1:0]                    count;
   logic [PW-1:0]                    head_ptr;
   logic [DEPTH-1:0][SB_ENTRY_W-1:0] entries;
   sb_entry_t                        head_e;
   logic                             fwd_hit;
   logic [31:0]                      fwd_data;

   assign push_data = {dataaddr[31:2], writedata};
   assign head_e    = head_data;

   sb_fifo #(.DEPTH(DEPTH), .EW(SB_ENTRY_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .head_ptr  (head_ptr),
      .entries   (entries)
   );

`ifdef STORE_BUF_FWD_EN
   // Walk oldest to youngest so the last hit is the youngest store to that word.
   always_comb begin
      sb_entry_t     e;
      logic [PW-1:0] idx;
      e        = '0;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_ptr + PW'(i);
         e   = entries[idx];
         if ((CW'(i) < count) && (e.addr == dataaddr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = e.data;
         end
      end
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
   logic unused_fwd;
   assign unused_fwd = ^{entries, head_ptr, count};
`endif

   logic unused_lsb;
   assign unused_lsb = ^dataaddr[1:0];

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      stall     = 1'b0;
      push      = 1'b0;
      readdata  = '0;
      case (state_q)
         IDLE: begin
            if (memwrite) begin
               // No full-bypass: a same-cycle drain does not free a slot for this store.
               stall = full;
               push  = !full;
            end else if (memread) begin
               if (fwd_hit) begin
                  readdata = fwd_data;
               end else begin
                  stall = 1'b1;
                  if (empty) begin
                     state_d   = RD_REQ;
                     rd_addr_d = dataaddr[31:2];
                  end
               end
            end
         end
         RD_REQ: begin
            stall = 1'b1;
            if (mem_ready)
               state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid) begin
               readdata = mem_rdata;
               state_d  = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory port depends only on registered state so CPU inputs never reach it.
   always_comb begin
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == IDLE && !empty) begin
         mem_valid = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = {head_e.addr, 2'b00};
         mem_wdata = head_e.data;
      end else if (state_q == RD_REQ) begin
         mem_valid = 1'b1;
         mem_addr  = {rd_addr_q, 2'b00};
      end
   end

   assign pop = mem_valid & mem_we & mem_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: inputs driven 1 time unit after the rising
// edge, outputs sampled on the falling edge against hand-computed values.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite, memread;
   logic [31:0] dataaddr, writedata, readdata;
   logic        stall, mem_valid, mem_we, mem_ready, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .memwrite   (memwrite),
      .memread    (memread),
      .dataaddr   (dataaddr),
      .writedata  (writedata),
      .readdata   (readdata),
      .stall      (stall),
      .mem_valid  (mem_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid)
   );

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk1 ({tag, "_stall"},  stall,     1'b0);
      chk1 ({tag, "_valid"},  mem_valid, 1'b0);
      chk1 ({tag, "_we"},     mem_we,    1'b0);
      chk32({tag, "_addr"},   mem_addr,  32'h0);
      chk32({tag, "_wdata"},  mem_wdata, 32'h0);
      chk32({tag, "_rdata"},  readdata,  32'h0);
   endtask

   initial begin
      reset = 1'b0; memwrite = 1'b0; memread = 1'b0; dataaddr = '0; writedata = '0;
      mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
      nxt(); nxt();
      smp(); chk_zero("rst");

      // single store
      nxt(); reset = 1'b1;
      memwrite = 1'b1; dataaddr = 32'd80; writedata = 32'd12; mem_ready = 1'b1;
      smp(); chk1("st_stall", stall, 1'b0); chk1("st_pre_valid", mem_valid, 1'b0);
      nxt(); memwrite = 1'b0;
      smp(); chk1("st_valid", mem_valid, 1'b1); chk1("st_we", mem_we, 1'b1);
      chk32("st_addr", mem_addr, 32'd80); chk32("st_wdata", mem_wdata, 32'd12);
      chk1("st_stall2", stall, 1'b0);
      nxt();
      smp(); chk1("st_empty", mem_valid, 1'b0); chk1("st_stall3", stall, 1'b0);

      // fill to full with memory blocked
      for (int k = 0; k < 4; k++) begin
         nxt(); mem_ready = 1'b0; memwrite = 1'b1;
         dataaddr = 32'(4 * k); writedata = 32'(100 + 4 * k);
         smp(); chk1("full_fill_stall", stall, 1'b0);
      end
      nxt(); dataaddr = 32'd16; writedata = 32'd116;
      smp(); chk1("full_stall", stall, 1'b1); chk1("full_valid", mem_valid, 1'b1);
      chk32("full_head", mem_addr, 32'd0);
      nxt(); mem_ready = 1'b1;
      smp(); chk1("full_nobypass", stall, 1'b1); chk32("full_d0", mem_addr, 32'd0);
      chk32("full_d0_data", mem_wdata, 32'd100);
      nxt();
      smp(); chk1("full_accept", stall, 1'b0); chk32("full_d4", mem_addr, 32'd4);
      nxt(); memwrite = 1'b0;
      smp(); chk32("full_d8", mem_addr, 32'd8);
      nxt();
      smp(); chk32("full_d12", mem_addr, 32'd12);
      nxt();
      smp(); chk32("full_d16", mem_addr, 32'd16); chk32("full_d16_data", mem_wdata, 32'd116);
      nxt();
      smp(); chk1("full_drained", mem_valid, 1'b0);

      // simultaneous push and pop at count 2
      nxt(); mem_ready = 1'b0; memwrite = 1'b1; dataaddr = 32'd200; writedata = 32'd1;
      nxt(); dataaddr = 32'd204; writedata = 32'd2;
      nxt(); dataaddr = 32'd208; writedata = 32'd3; mem_ready = 1'b1;
      smp(); chk1("pp_stall", stall, 1'b0); chk32("pp_a200", mem_addr, 32'd200);
      nxt(); memwrite = 1'b0; mem_ready = 1'b0;
      smp(); chk32("pp_a204_hold", mem_addr, 32'd204); chk32("pp_d204", mem_wdata, 32'd2);
      nxt(); mem_ready = 1'b1;
      smp(); chk32("pp_a204", mem_addr, 32'd204);
      nxt();
      smp(); chk32("pp_a208", mem_addr, 32'd208); chk32("pp_d208", mem_wdata, 32'd3);
      nxt();
      smp(); chk1("pp_empty", mem_valid, 1'b0);

      // load behind two stores
      nxt(); mem_ready = 1'b0; memwrite = 1'b1; dataaddr = 32'd80; writedata = 32'd12;
      nxt(); dataaddr = 32'd84; writedata = 32'd34;
      nxt(); memwrite = 1'b0; memread = 1'b1; dataaddr = 32'd100;
      smp(); chk1("ld_stall0", stall, 1'b1); chk32("ld_w80", mem_addr, 32'd80);
      chk1("ld_we0", mem_we, 1'b1);
      nxt(); mem_ready = 1'b1;
      smp(); chk1("ld_stall1", stall, 1'b1); chk32("ld_w80b", mem_addr, 32'd80);
      nxt();
      smp(); chk1("ld_stall2", stall, 1'b1); chk32("ld_w84", mem_addr, 32'd84);
      nxt();
      smp(); chk1("ld_stall3", stall, 1'b1); chk1("ld_gap", mem_valid, 1'b0);
      nxt();
      smp(); chk1("ld_req_valid", mem_valid, 1'b1); chk1("ld_req_we", mem_we, 1'b0);
      chk32("ld_req_addr", mem_addr, 32'd100); chk1("ld_req_stall", stall, 1'b1);
      nxt();
      smp(); chk1("ld_wait_stall", stall, 1'b1); chk1("ld_wait_valid", mem_valid, 1'b0);
      nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      smp(); chk1("ld_done_stall", stall, 1'b0); chk32("ld_data", readdata, 32'hCAFE_F00D);
      nxt(); mem_rvalid = 1'b0; memread = 1'b0;
      smp(); chk32("ld_rd_idle", readdata, 32'h0); chk1("ld_idle_valid", mem_valid, 1'b0);

      // load on empty buffer, immediate memory response
      nxt(); memread = 1'b1; dataaddr = 32'h47;
      smp(); chk1("le_stall0", stall, 1'b1); chk1("le_valid0", mem_valid, 1'b0);
      nxt();
      smp(); chk1("le_req", mem_valid, 1'b1); chk32("le_addr", mem_addr, 32'h44);
      nxt(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
      smp(); chk1("le_stall2", stall, 1'b0); chk32("le_data", readdata, 32'h0000_1234);
      nxt(); mem_rvalid = 1'b0; memread = 1'b0;

      // same-address stores then a load to that word
      mem_ready = 1'b0; memwrite = 1'b1; dataaddr = 32'd80; writedata = 32'd12;
      nxt(); writedata = 32'd7;
      nxt(); memwrite = 1'b0; memread = 1'b1; dataaddr = 32'd80;
      smp();
`ifdef STORE_BUF_FWD_EN
      chk1("fwd_stall", stall, 1'b0); chk32("fwd_data", readdata, 32'd7);
`else
      chk1("nofwd_stall", stall, 1'b1); chk32("nofwd_data", readdata, 32'h0);
`endif
      chk1("fwd_port_we", mem_we, 1'b1); chk32("fwd_port_addr", mem_addr, 32'd80);
      nxt(); memread = 1'b0; mem_ready = 1'b1;
      nxt(); nxt();
      smp(); chk1("fwd_drained", mem_valid, 1'b0);

      // reset while stores are buffered
      nxt(); mem_ready = 1'b0; memwrite = 1'b1; dataaddr = 32'h300; writedata = 32'd1;
      nxt(); dataaddr = 32'h304;
      nxt(); dataaddr = 32'h308;
      nxt(); memwrite = 1'b0; reset = 1'b0;
      smp(); chk_zero("mid_rst");
      nxt(); reset = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'd55;
      smp(); chk1("post_rst_valid", mem_valid, 1'b0); chk32("post_rst_rdata", readdata, 32'h0);
      chk1("post_rst_stall", stall, 1'b0);
      nxt(); mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         smp(); chk1("post_rst_nowrite", mem_valid, 1'b0);
         nxt();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
